// File: rtl/draw_arb_pkg.sv
// Shared types and defaults for the object draw arbiter.
package draw_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 8;
  localparam int unsigned DEF_RGB_W   = 8;

  localparam logic [DEF_RGB_W-1:0] DEF_TRANSPARENT = 8'hFF;
  localparam logic [DEF_RGB_W-1:0] DEF_BG_COLOR    = 8'h00;

  typedef logic [DEF_RGB_W-1:0] rgb_t;

  typedef enum logic {WAIT_SOF, ACTIVE} arb_state_t;

  // Owner index width, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_priority_enc.sv
// Combinational lowest-index-first priority encoder.
module draw_priority_enc #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     vis,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Scan downwards so the lowest set index is written last and wins.
    for (int unsigned i = N; i > 0; i--) begin
      if (vis[i-1]) begin
        idx = IDX_W'(i - 1);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/object_draw_arbiter.sv
// Two-stage pixel arbiter between object drawers with per-frame player collision flags.
// Collision tracking is built only when DRAW_ARB_COLLISION_EN is defined.
module object_draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int unsigned          NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned          RGB_W       = DEF_RGB_W,
  parameter logic [RGB_W-1:0]     TRANSPARENT = DEF_TRANSPARENT,
  parameter logic [RGB_W-1:0]     BG_COLOR    = DEF_BG_COLOR
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                startOfFrame,
  input  logic                                pix_valid,
  input  logic [NUM_REQ-1:0]                  req_draw,
  input  logic [NUM_REQ-1:0][RGB_W-1:0]       req_rgb,
  output logic [RGB_W-1:0]                    out_rgb,
  output logic                                out_valid,
  output logic [idx_width(NUM_REQ)-1:0]       out_owner,
  output logic                                out_hit,
  output logic [NUM_REQ-2:0]                  coll_vec,
  output logic                                coll_valid
);

  localparam int unsigned OWN_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]            vis_now;
  logic [NUM_REQ-1:0]            vis_s1;
  logic [NUM_REQ-1:0][RGB_W-1:0] rgb_s1;
  logic                          pv_s1;
  logic                          sof_s1;
  logic [OWN_W-1:0]              win_idx;
  logic                          win_any;
  arb_state_t                    state;

  always_comb begin
    vis_now = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      vis_now[i] = pix_valid & req_draw[i] & (req_rgb[i] != TRANSPARENT);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vis_s1 <= '0;
      rgb_s1 <= '0;
      pv_s1  <= 1'b0;
      sof_s1 <= 1'b0;
    end else begin
      vis_s1 <= vis_now;
      rgb_s1 <= req_rgb;
      pv_s1  <= pix_valid;
      sof_s1 <= startOfFrame;
    end
  end

  draw_priority_enc #(
    .N     (NUM_REQ),
    .IDX_W (OWN_W)
  ) u_prio (
    .vis (vis_s1),
    .idx (win_idx),
    .any (win_any)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      out_rgb   <= BG_COLOR;
      out_valid <= 1'b0;
      out_owner <= '0;
      out_hit   <= 1'b0;
    end else begin
      out_rgb   <= win_any ? rgb_s1[win_idx] : BG_COLOR;
      out_valid <= pv_s1;
      out_owner <= win_any ? win_idx : '0;
      out_hit   <= win_any;
    end
  end

  // The FSM advances on the S1-delayed SOF so it stays aligned with the S1 pixel
  // that the collision logic evaluates in the same cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= WAIT_SOF;
    end else begin
      case (state)
        WAIT_SOF: if (sof_s1) state <= ACTIVE;
        ACTIVE:   state <= ACTIVE;
        default:  state <= WAIT_SOF;
      endcase
    end
  end

`ifdef DRAW_ARB_COLLISION_EN
  logic [NUM_REQ-2:0] pend;
  logic [NUM_REQ-2:0] hits;

  assign hits = {(NUM_REQ-1){vis_s1[0]}} & vis_s1[NUM_REQ-1:1];

  // On SOF the current pixel opens the new frame; only a frame begun in ACTIVE is published.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pend       <= '0;
      coll_vec   <= '0;
      coll_valid <= 1'b0;
    end else begin
      coll_valid <= 1'b0;
      if (sof_s1) begin
        pend <= hits;
        if (state == ACTIVE) begin
          coll_vec   <= pend;
          coll_valid <= 1'b1;
        end
      end else if (state == ACTIVE) begin
        pend <= pend | hits;
      end
    end
  end
`else
  logic unused_state;

  assign unused_state = (state == ACTIVE);
  assign coll_vec     = '0;
  assign coll_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_object_draw_arbiter.sv
// Directed plus randomized bench for object_draw_arbiter against a frame-level reference model.
module tb_object_draw_arbiter;
  import draw_arb_pkg::*;

  localparam int N = 8;
  localparam int W = 8;
`ifdef DRAW_ARB_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  startOfFrame;
  logic                  pix_valid;
  logic [N-1:0]          req_draw;
  logic [N-1:0][W-1:0]   req_rgb;
  logic [W-1:0]          out_rgb;
  logic                  out_valid;
  logic [2:0]            out_owner;
  logic                  out_hit;
  logic [N-2:0]          coll_vec;
  logic                  coll_valid;

  always #5 clk = ~clk;

  object_draw_arbiter #(
    .NUM_REQ     (N),
    .RGB_W       (W),
    .TRANSPARENT (8'hFF),
    .BG_COLOR    (8'h00)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .pix_valid    (pix_valid),
    .req_draw     (req_draw),
    .req_rgb      (req_rgb),
    .out_rgb      (out_rgb),
    .out_valid    (out_valid),
    .out_owner    (out_owner),
    .out_hit      (out_hit),
    .coll_vec     (coll_vec),
    .coll_valid   (coll_valid)
  );

  typedef struct packed {
    logic [7:0] rgb;
    logic       valid;
    logic [2:0] owner;
    logic       hit;
    logic [6:0] cvec;
    logic       cval;
  } exp_t;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  exp_t        exp_cur;
  exp_t        exp_nxt;
  logic [6:0]  m_pend;
  logic [6:0]  m_hold;
  bit          m_seen;

  function automatic exp_t reset_exp();
    exp_t e;
    e = '0;
    e.rgb = 8'h00;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic compare_all(input exp_t e);
    check("out_rgb",    32'(out_rgb),    32'(e.rgb));
    check("out_valid",  32'(out_valid),  32'(e.valid));
    check("out_owner",  32'(out_owner),  32'(e.owner));
    check("out_hit",    32'(out_hit),    32'(e.hit));
    check("coll_vec",   32'(coll_vec),   32'(e.cvec));
    check("coll_valid", 32'(coll_valid), 32'(e.cval));
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_hold = '0;
    m_seen = 1'b0;
  endtask

  // Frame-level model: winner is the smallest visible index; collisions collected between SOFs.
  task automatic model_pixel(output exp_t e);
    bit         vis[N];
    int         visible[$];
    logic [6:0] hits;
    e = '0;
    for (int i = 0; i < N; i++) begin
      vis[i] = pix_valid && req_draw[i] && (req_rgb[i] != 8'hFF);
      if (vis[i]) visible.push_back(i);
    end
    e.valid = pix_valid;
    e.hit   = (visible.size() > 0);
    e.rgb   = e.hit ? req_rgb[visible[0]] : 8'h00;
    e.owner = e.hit ? 3'(visible[0]) : 3'd0;
    hits = '0;
    for (int k = 1; k < N; k++) hits[k-1] = vis[0] && vis[k];
    if (COLL_EN) begin
      if (startOfFrame) begin
        if (m_seen) begin
          m_hold = m_pend;
          e.cval = 1'b1;
        end
        m_pend = hits;
        m_seen = 1'b1;
      end else if (m_seen) begin
        m_pend = m_pend | hits;
      end
      e.cvec = m_hold;
    end
  endtask

  // One cycle: outputs seen after this edge belong to the previous step's inputs.
  task automatic step();
    if (resetN) model_pixel(exp_nxt);
    else        exp_nxt = reset_exp();
    @(posedge clk);
    #1;
    compare_all(exp_cur);
    exp_cur = exp_nxt;
  endtask

  task automatic idle(input bit sof);
    pix_valid    = 1'b0;
    req_draw     = '0;
    req_rgb      = '0;
    startOfFrame = sof;
  endtask

  task automatic rand_px();
    pix_valid    = ($urandom_range(3) != 0);
    startOfFrame = ($urandom_range(19) == 0);
    req_draw     = 8'($urandom);
    for (int i = 0; i < N; i++)
      req_rgb[i] = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
  endtask

  task automatic do_reset(input int cycles);
    resetN = 1'b0;
    #1;
    model_reset();
    exp_cur = reset_exp();
    compare_all(exp_cur);
    for (int c = 0; c < cycles; c++) step();
    resetN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN = 1'b1;
    rand_px();
    exp_cur = reset_exp();
    #1;
    do_reset(3);

    // Latency: pixel appears two edges after pix_valid.
    idle(1'b0);
    pix_valid = 1'b1; req_draw = 8'h01; req_rgb[0] = 8'h42;
    step();
    check("t1_lat1_valid", 32'(out_valid), 32'd0);
    idle(1'b0);
    step();
    check("t1_lat2_valid", 32'(out_valid), 32'd1);
    check("t1_lat2_rgb",   32'(out_rgb),   32'h42);

    // Lowest index wins.
    idle(1'b0);
    pix_valid = 1'b1; req_draw = 8'b0000_0110; req_rgb[1] = 8'h1C; req_rgb[2] = 8'hE0;
    step();
    idle(1'b0);
    step();
    check("t2_rgb",   32'(out_rgb),   32'h1C);
    check("t2_owner", 32'(out_owner), 32'd1);
    check("t2_hit",   32'(out_hit),   32'd1);

    // Transparent requester loses.
    idle(1'b0);
    pix_valid = 1'b1; req_draw = 8'b0000_1010; req_rgb[1] = 8'hFF; req_rgb[3] = 8'h03;
    step();
    idle(1'b0);
    step();
    check("t3_rgb",   32'(out_rgb),   32'h03);
    check("t3_owner", 32'(out_owner), 32'd3);

    // Collision between player and drawer 4.
    idle(1'b1); step();
    idle(1'b0); step();
    check("t4_first_sof_cval", 32'(coll_valid), 32'd0);
    pix_valid = 1'b1; req_draw = 8'h11; req_rgb[0] = 8'h10; req_rgb[4] = 8'h20;
    step();
    idle(1'b0); step();
    idle(1'b1); step();
    idle(1'b0); step();
    check("t4_cval", 32'(coll_valid), 32'(COLL_EN));
    check("t4_cvec", 32'(coll_vec),   COLL_EN ? 32'h08 : 32'h0);
    idle(1'b1); step();
    idle(1'b0); step();
    check("t4_empty_cval", 32'(coll_valid), 32'(COLL_EN));
    check("t4_empty_cvec", 32'(coll_vec),   32'h0);

    // Overlap on the SOF pixel belongs to the new frame.
    idle(1'b1);
    pix_valid = 1'b1; req_draw = 8'h05; req_rgb[0] = 8'h11; req_rgb[2] = 8'h22;
    step();
    idle(1'b0); step();
    check("t5_cval", 32'(coll_valid), 32'(COLL_EN));
    check("t5_cvec", 32'(coll_vec),   32'h0);
    idle(1'b1); step();
    idle(1'b0); step();
    check("t5_next_cvec", 32'(coll_vec), COLL_EN ? 32'h02 : 32'h0);

    // Reset mid-frame discards partial collisions.
    idle(1'b0);
    pix_valid = 1'b1; req_draw = 8'h21; req_rgb[0] = 8'h11; req_rgb[5] = 8'h55;
    step();
    idle(1'b0); step();
    do_reset(2);
    idle(1'b1); step();
    idle(1'b0); step();
    check("t6_first_cval", 32'(coll_valid), 32'd0);
    check("t6_first_cvec", 32'(coll_vec),   32'h0);
    idle(1'b1); step();
    idle(1'b0); step();
    check("t6_second_cval", 32'(coll_valid), 32'(COLL_EN));
    check("t6_second_cvec", 32'(coll_vec),   32'h0);

    // Randomized traffic with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        rand_px();
        do_reset(2);
      end
      rand_px();
      step();
    end
    idle(1'b0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
